irq_pending_ctrl: RTL and testbench

- Request-capture and handshake stage that sits directly upstream of the 8-input priority encoder.
- Latches rising edges on 8 request lines into a pending register and applies a mask. The masked pending vector drives the encoder input, and the 3-bit encoded index comes back in.
- Presents the winning index to a consumer over a valid/ready handshake, then clears that pending bit.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_edge_capture.sv | 55 +++++
 rtl/irq_pending_ctrl.sv | 81 ++++++++
 tb/tb_irq_pending_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, types and helpers for the interrupt pending controller
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    GAP   = 2'd2
  } irq_state_t;

  function automatic req_vec_t idx_onehot(input idx_t idx);
    req_vec_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// rtl/irq_edge_capture.sv - rising-edge capture into pending register; IRQ_PENDING_OVERFLOW_EN adds lost-event flags
module irq_edge_capture
  import irq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req_in,
  input  req_vec_t clr,
`ifdef IRQ_PENDING_OVERFLOW_EN
  input  req_vec_t ovf_clr,
  output req_vec_t ovf_vec,
`endif
  output req_vec_t pending_q
);

  req_vec_t r_req_q;
  req_vec_t r_pending;
  req_vec_t w_edge;
  req_vec_t w_pending_nxt;

  assign w_edge = req_in & ~r_req_q;

  // A new edge wins over a same-cycle clear so the fresh event is not lost.
  assign w_pending_nxt = w_edge | (r_pending & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
    end else begin
      r_req_q   <= req_in;
      r_pending <= w_pending_nxt;
    end
  end

  assign pending_q = r_pending;

`ifdef IRQ_PENDING_OVERFLOW_EN
  req_vec_t r_ovf;
  req_vec_t w_ovf_set;

  assign w_ovf_set = w_edge & r_pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~ovf_clr);
    end
  end

  assign ovf_vec = r_ovf;
`endif

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending capture, mask and valid/ready presentation of the encoded winner; IRQ_PENDING_OVERFLOW_EN adds ovf_vec/ovf_clr
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req_in,
  input  req_vec_t mask_in,
  output req_vec_t pend_vec,
  input  idx_t     enc_idx,
  output logic     irq_valid,
  output idx_t     irq_id,
  input  logic     irq_ready,
`ifdef IRQ_PENDING_OVERFLOW_EN
  input  req_vec_t ovf_clr,
  output req_vec_t ovf_vec,
`endif
  output req_vec_t pending_q
);

  irq_state_t r_state;
  logic       r_irq_valid;
  idx_t       r_irq_id;
  req_vec_t   w_pending;
  req_vec_t   w_clr;
  logic       w_accept;

  assign w_accept = r_irq_valid & irq_ready;
  assign w_clr    = w_accept ? idx_onehot(r_irq_id) : '0;

  irq_edge_capture u_capture (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .clr       (w_clr),
`ifdef IRQ_PENDING_OVERFLOW_EN
    .ovf_clr   (ovf_clr),
    .ovf_vec   (ovf_vec),
`endif
    .pending_q (w_pending)
  );

  assign pend_vec  = w_pending & mask_in;
  assign pending_q = w_pending;

  // GAP lets the cleared bit ripple through the external encoder before the next pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|pend_vec) begin
            r_irq_id    <= enc_idx;
            r_irq_valid <= 1'b1;
            r_state     <= VALID;
          end
        end
        VALID: begin
          if (irq_ready) begin
            r_irq_valid <= 1'b0;
            r_state     <= GAP;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_irq_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - self-checking bench for irq_pending_ctrl with a behavioural encoder
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic [7:0] pend_vec;
  logic [2:0] enc_idx;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ready;
  logic [7:0] pending_q;
`ifdef IRQ_PENDING_OVERFLOW_EN
  logic [7:0] ovf_clr;
  logic [7:0] ovf_vec;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .pend_vec  (pend_vec),
    .enc_idx   (enc_idx),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
`ifdef IRQ_PENDING_OVERFLOW_EN
    .ovf_clr   (ovf_clr),
    .ovf_vec   (ovf_vec),
`endif
    .pending_q (pending_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Highest set index wins.
  always_comb begin
    enc_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (pend_vec[i]) enc_idx = 3'(i);
  end

  // Scoreboard: each accepted handshake pops the next expected id.
  always @(negedge clk) begin
    if (!rst && irq_valid === 1'b1 && irq_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: handshake id=%0d with no expected entry", irq_id);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (irq_id !== e) begin
          n_err++;
          $display("FAIL sb_id: got %0d expected %0d", irq_id, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (irq_valid !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    n_cmp++;
    if (irq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wait_valid: irq_valid=%b after %0d cycles, expected 1", irq_valid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 8'h00; mask_in = 8'hFF; irq_ready = 1'b0;
`ifdef IRQ_PENDING_OVERFLOW_EN
    ovf_clr = 8'h00;
`endif
    tick(); tick();
    n_cmp += 4;
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", irq_valid); end
    if (irq_id !== 3'd0) begin n_err++; $display("FAIL rst_id: got %0d expected 0", irq_id); end
    if (pending_q !== 8'h00) begin n_err++; $display("FAIL rst_pending: got %h expected 00", pending_q); end
    if (pend_vec !== 8'h00) begin n_err++; $display("FAIL rst_pend_vec: got %h expected 00", pend_vec); end
`ifdef IRQ_PENDING_OVERFLOW_EN
    n_cmp++;
    if (ovf_vec !== 8'h00) begin n_err++; $display("FAIL rst_ovf: got %h expected 00", ovf_vec); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    irq_ready = 1'b1; req_in = 8'h04;
    exp_q.push_back(3'd2);
    tick();
    n_cmp += 2;
    if (pending_q !== 8'h04) begin n_err++; $display("FAIL single_pend: got %h expected 04", pending_q); end
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b expected 0", irq_valid); end
    tick();
    n_cmp += 2;
    if (irq_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", irq_valid); end
    if (irq_id !== 3'd2) begin n_err++; $display("FAIL single_id: got %0d expected 2", irq_id); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (pending_q !== 8'h00) begin n_err++; $display("FAIL single_held_pend: cyc %0d got %h expected 00", i, pending_q); end
      if (irq_valid !== 1'b0) begin n_err++; $display("FAIL single_held_valid: cyc %0d got %b expected 0", i, irq_valid); end
      tick();
    end
    req_in = 8'h00;
    tick();
  endtask

  task automatic test_priority();
    irq_ready = 1'b1; req_in = 8'h81;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    tick();
    req_in = 8'h00;
    tick();
    n_cmp += 2;
    if (irq_valid !== 1'b1) begin n_err++; $display("FAIL prio_first_valid: got %b expected 1", irq_valid); end
    if (irq_id !== 3'd7) begin n_err++; $display("FAIL prio_first_id: got %0d expected 7", irq_id); end
    tick(); tick();
    n_cmp++;
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_gap: got %b expected 0", irq_valid); end
    tick();
    n_cmp += 2;
    if (irq_valid !== 1'b1) begin n_err++; $display("FAIL prio_second_valid: got %b expected 1", irq_valid); end
    if (irq_id !== 3'd0) begin n_err++; $display("FAIL prio_second_id: got %0d expected 0", irq_id); end
    tick(); tick();
    n_cmp += 2;
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL prio_idle: got %b expected 0", irq_valid); end
    if (pending_q !== 8'h00) begin n_err++; $display("FAIL prio_pend: got %h expected 00", pending_q); end
  endtask

  task automatic test_backpressure();
    irq_ready = 1'b0; req_in = 8'h10;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd6);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_in = 8'h50;
      n_cmp += 2;
      if (irq_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: cyc %0d got %b expected 1", i, irq_valid); end
      if (irq_id !== 3'd4) begin n_err++; $display("FAIL bp_id: cyc %0d got %0d expected 4", i, irq_id); end
      tick();
    end
    irq_ready = 1'b1;
    tick();
    n_cmp++;
    if (pending_q !== 8'h40) begin n_err++; $display("FAIL bp_pend: got %h expected 40", pending_q); end
    wait_valid(8);
    n_cmp++;
    if (irq_id !== 3'd6) begin n_err++; $display("FAIL bp_next_id: got %0d expected 6", irq_id); end
    tick();
    req_in = 8'h00;
    tick(); tick();
  endtask

  task automatic test_mask();
    irq_ready = 1'b1; mask_in = 8'h00; req_in = 8'h02;
    tick();
    req_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp += 2;
      if (irq_valid !== 1'b0) begin n_err++; $display("FAIL mask_valid: cyc %0d got %b expected 0", i, irq_valid); end
      if (pending_q !== 8'h02) begin n_err++; $display("FAIL mask_pend: cyc %0d got %h expected 02", i, pending_q); end
    end
    exp_q.push_back(3'd1);
    mask_in = 8'h02;
    tick();
    n_cmp += 2;
    if (irq_valid !== 1'b1) begin n_err++; $display("FAIL unmask_valid: got %b expected 1", irq_valid); end
    if (irq_id !== 3'd1) begin n_err++; $display("FAIL unmask_id: got %0d expected 1", irq_id); end
    tick(); tick();
    mask_in = 8'hFF;
  endtask

  task automatic test_collision_reset();
    irq_ready = 1'b0; req_in = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    req_in = 8'h00;
    tick();
    irq_ready = 1'b1; req_in = 8'h08;
    exp_q.push_back(3'd3);
    tick();
    n_cmp += 2;
    if (pending_q[3] !== 1'b1) begin n_err++; $display("FAIL coll_pend: got %b expected 1", pending_q[3]); end
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL coll_valid: got %b expected 0", irq_valid); end
    req_in = 8'h00;
    wait_valid(8);
    n_cmp++;
    if (irq_id !== 3'd3) begin n_err++; $display("FAIL coll_again_id: got %0d expected 3", irq_id); end
    tick();
    n_cmp++;
    if (pending_q !== 8'h00) begin n_err++; $display("FAIL coll_drain: got %h expected 00", pending_q); end
    tick(); tick();

    irq_ready = 1'b0; req_in = 8'h24;
    tick(); tick();
    n_cmp++;
    if (irq_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %b expected 1", irq_valid); end
    rst = 1'b1; req_in = 8'h00;
    tick();
    n_cmp += 2;
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", irq_valid); end
    if (pending_q !== 8'h00) begin n_err++; $display("FAIL rstmid_pend: got %h expected 00", pending_q); end
    rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if (irq_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_after: got %b expected 0", irq_valid); end
  endtask

`ifdef IRQ_PENDING_OVERFLOW_EN
  task automatic test_overflow();
    irq_ready = 1'b0; req_in = 8'h20;
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h20;
    tick();
    req_in = 8'h00;
    n_cmp++;
    if (ovf_vec !== 8'h20) begin n_err++; $display("FAIL ovf_set: got %h expected 20", ovf_vec); end
    ovf_clr = 8'h20;
    tick();
    ovf_clr = 8'h00;
    n_cmp++;
    if (ovf_vec !== 8'h00) begin n_err++; $display("FAIL ovf_clr: got %h expected 00", ovf_vec); end
    exp_q.push_back(3'd5);
    irq_ready = 1'b1;
    tick(); tick();
    n_cmp += 2;
    if (pending_q !== 8'h00) begin n_err++; $display("FAIL ovf_drain: got %h expected 00", pending_q); end
    if (ovf_vec !== 8'h00) begin n_err++; $display("FAIL ovf_after: got %h expected 00", ovf_vec); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_mask();
    test_collision_reset();
`ifdef IRQ_PENDING_OVERFLOW_EN
    test_overflow();
`endif
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected handshakes never seen, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
